clarkpark_pipe: RTL and testbench

Parametrised, valid-qualified successor to the fixed forward Clarke/Park block. It runs a fixed 4-stage pipeline and supports per-sample mode select. Forward mode maps abc to d/q plus the zero-sequence component; inverse mode maps d/q to abc. All outputs saturate, with per-sample and sticky saturation flags. It sits between the current/voltage sampling front end and the FOC regulators, and on the inverse path toward PWM generation.

---
 rtl/clarkpark_pipe_if.sv | 37 +++
 rtl/clarkpark_pipe.sv | 232 +++++++++++++++++++++++
 tb/tb_clarkpark_pipe.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/clarkpark_pipe_if.sv
// +---------------------------------------------------------------------------+
// | clarkpark_pipe_if : sample/result bundle for the Clarke/Park pipeline       |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
`default_nettype none

interface clarkpark_pipe_if #(
    parameter int pw_io_width = 16
);
    logic                          i_valid;
    logic                          ip_mode;
    logic signed [pw_io_width-1:0] isp_a;
    logic signed [pw_io_width-1:0] isp_b;
    logic signed [pw_io_width-1:0] isp_c;
    logic signed [pw_io_width-1:0] isp_sine;
    logic signed [pw_io_width-1:0] isp_cosine;
    logic                          i_sat_clear;
    logic                          o_valid;
    logic                          op_mode;
    logic signed [pw_io_width-1:0] osp_x;
    logic signed [pw_io_width-1:0] osp_y;
    logic signed [pw_io_width-1:0] osp_z;
    logic [2:0]                    op_sat_flags;
    logic                          o_sat_sticky;

    modport slave (
        input  i_valid, ip_mode, isp_a, isp_b, isp_c, isp_sine, isp_cosine, i_sat_clear,
        output o_valid, op_mode, osp_x, osp_y, osp_z, op_sat_flags, o_sat_sticky
    );

    modport master (
        output i_valid, ip_mode, isp_a, isp_b, isp_c, isp_sine, isp_cosine, i_sat_clear,
        input  o_valid, op_mode, osp_x, osp_y, osp_z, op_sat_flags, o_sat_sticky
    );
endinterface

`default_nettype wire

// File: rtl/clarkpark_pipe.sv
// +---------------------------------------------------------------------------+
// | clarkpark_pipe : valid-qualified forward/inverse Clarke-Park, 4-cycle pipe  |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
`default_nettype none

module clarkpark_pipe #(
    parameter int pw_io_width         = 16,
    parameter int pw_io_decimal_width = 15,
    parameter int p_2div3             = 21845,
    parameter int p_1div3             = 10922,
    parameter int p_sqrt3div3         = 18918,
    parameter int p_sqrt3div2         = 28378
) (
    input  wire logic        clk,
    input  wire logic        reset,
    clarkpark_pipe_if.slave  bus
);
    localparam int W  = pw_io_width;
    localparam int F  = pw_io_decimal_width;
    localparam int IW = 2*W + 3;
    localparam int NW = W + 2;

    localparam logic signed [IW-1:0] c_k2div3  = IW'(p_2div3);
    localparam logic signed [IW-1:0] c_k1div3  = IW'(p_1div3);
    localparam logic signed [IW-1:0] c_ks3div3 = IW'(p_sqrt3div3);
    localparam logic signed [IW-1:0] c_ks3div2 = IW'(p_sqrt3div2);
    localparam logic signed [IW-1:0] c_sat_hi  = IW'((2**(W-1)) - 1);
    localparam logic signed [IW-1:0] c_sat_lo  = ~c_sat_hi;

    // Returns {overflow flag, clamped value}.
    function automatic logic [W:0] f_sat(input logic signed [IW-1:0] v);
        if (v > c_sat_hi)      f_sat = {2'b10, {(W-1){1'b1}}};
        else if (v < c_sat_lo) f_sat = {2'b11, {(W-1){1'b0}}};
        else                   f_sat = {1'b0, v[W-1:0]};
    endfunction

    // Input capture
    logic                 r0_valid, r0_mode;
    logic signed [W-1:0]  r0_a, r0_b, r0_c, r0_sin, r0_cos;

    always_ff @(posedge clk) begin
        if (reset) begin
            r0_valid <= 1'b0;
            r0_mode  <= 1'b0;
            r0_a     <= '0;
            r0_b     <= '0;
            r0_c     <= '0;
            r0_sin   <= '0;
            r0_cos   <= '0;
        end else begin
            r0_valid <= bus.i_valid;
            if (bus.i_valid) begin
                r0_mode <= bus.ip_mode;
                r0_a    <= bus.isp_a;
                r0_b    <= bus.isp_b;
                r0_c    <= bus.isp_c;
                r0_sin  <= bus.isp_sine;
                r0_cos  <= bus.isp_cosine;
            end
        end
    end

    // S1: Clarke transform (forward) or pass-through of d/q (inverse)
    logic signed [IW-1:0] w1_a, w1_b, w1_c;
    logic signed [NW-1:0] w1_u, w1_v, w1_zs;

    assign w1_a = IW'(r0_a);
    assign w1_b = IW'(r0_b);
    assign w1_c = IW'(r0_c);

    always_comb begin
        w1_u  = NW'(r0_a);
        w1_v  = NW'(r0_b);
        w1_zs = '0;
        if (!r0_mode) begin
            w1_u  = NW'((w1_a * c_k2div3 - c_k1div3 * (w1_b + w1_c)) >>> F);
            w1_v  = NW'((c_ks3div3 * (w1_b - w1_c)) >>> F);
            w1_zs = NW'((c_k1div3 * (w1_a + w1_b + w1_c)) >>> F);
        end
    end

    logic                 r1_valid, r1_mode;
    logic signed [NW-1:0] r1_u, r1_v, r1_zs;
    logic signed [W-1:0]  r1_sin, r1_cos;

    always_ff @(posedge clk) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r1_mode  <= 1'b0;
            r1_u     <= '0;
            r1_v     <= '0;
            r1_zs    <= '0;
            r1_sin   <= '0;
            r1_cos   <= '0;
        end else begin
            r1_valid <= r0_valid;
            if (r0_valid) begin
                r1_mode <= r0_mode;
                r1_u    <= w1_u;
                r1_v    <= w1_v;
                r1_zs   <= w1_zs;
                r1_sin  <= r0_sin;
                r1_cos  <= r0_cos;
            end
        end
    end

    // S2: the four rotation products, shared by both modes
    logic                 r2_valid, r2_mode;
    logic signed [IW-1:0] r2_uc, r2_us, r2_vc, r2_vs;
    logic signed [NW-1:0] r2_zs;

    always_ff @(posedge clk) begin
        if (reset) begin
            r2_valid <= 1'b0;
            r2_mode  <= 1'b0;
            r2_uc    <= '0;
            r2_us    <= '0;
            r2_vc    <= '0;
            r2_vs    <= '0;
            r2_zs    <= '0;
        end else begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_mode <= r1_mode;
                r2_uc   <= IW'(r1_u) * IW'(r1_cos);
                r2_us   <= IW'(r1_u) * IW'(r1_sin);
                r2_vc   <= IW'(r1_v) * IW'(r1_cos);
                r2_vs   <= IW'(r1_v) * IW'(r1_sin);
                r2_zs   <= r1_zs;
            end
        end
    end

    // S3: rotation sums; forward rotates by -theta, inverse by +theta
    logic signed [NW-1:0] w3_m, w3_n;

    always_comb begin
        w3_m = NW'((r2_uc + r2_vs) >>> F);
        w3_n = NW'((r2_vc - r2_us) >>> F);
        if (r2_mode) begin
            w3_m = NW'((r2_uc - r2_vs) >>> F);
            w3_n = NW'((r2_us + r2_vc) >>> F);
        end
    end

    logic                 r3_valid, r3_mode;
    logic signed [NW-1:0] r3_m, r3_n, r3_zs;

    always_ff @(posedge clk) begin
        if (reset) begin
            r3_valid <= 1'b0;
            r3_mode  <= 1'b0;
            r3_m     <= '0;
            r3_n     <= '0;
            r3_zs    <= '0;
        end else begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r3_mode <= r2_mode;
                r3_m    <= w3_m;
                r3_n    <= w3_n;
                r3_zs   <= r2_zs;
            end
        end
    end

    // S4: inverse Clarke (inverse mode) and output saturation
    logic signed [IW-1:0] w4_m, w4_n, w4_half, w4_k;
    logic signed [IW-1:0] w4_x_pre, w4_y_pre, w4_z_pre;
    logic [W:0]           w4_x, w4_y, w4_z;
    logic [2:0]           w4_flags;

    assign w4_m    = IW'(r3_m);
    assign w4_n    = IW'(r3_n);
    assign w4_half = w4_m <<< (F-1);
    assign w4_k    = c_ks3div2 * w4_n;

    always_comb begin
        w4_x_pre = w4_m;
        w4_y_pre = w4_n;
        w4_z_pre = IW'(r3_zs);
        if (r3_mode) begin
            w4_y_pre = (-w4_half + w4_k) >>> F;
            w4_z_pre = (-w4_half - w4_k) >>> F;
        end
    end

    assign w4_x     = f_sat(w4_x_pre);
    assign w4_y     = f_sat(w4_y_pre);
    assign w4_z     = f_sat(w4_z_pre);
    assign w4_flags = {w4_z[W], w4_y[W], w4_x[W]};

    logic                r_o_valid, r_o_mode, r_sticky;
    logic signed [W-1:0] r_x, r_y, r_z;
    logic [2:0]          r_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_o_valid <= 1'b0;
            r_o_mode  <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_flags   <= '0;
            r_sticky  <= 1'b0;
        end else begin
            r_o_valid <= r3_valid;
            if (r3_valid) begin
                r_o_mode <= r3_mode;
                r_x      <= w4_x[W-1:0];
                r_y      <= w4_y[W-1:0];
                r_z      <= w4_z[W-1:0];
                r_flags  <= w4_flags;
            end
            // A saturation event presented in this cycle beats a clear.
            r_sticky <= (r3_valid & (|w4_flags)) | (r_sticky & ~bus.i_sat_clear);
        end
    end

    assign bus.o_valid      = r_o_valid;
    assign bus.op_mode      = r_o_mode;
    assign bus.osp_x        = r_x;
    assign bus.osp_y        = r_y;
    assign bus.osp_z        = r_z;
    assign bus.op_sat_flags = r_flags;
    assign bus.o_sat_sticky = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_clarkpark_pipe.sv
// +---------------------------------------------------------------------------+
// | tb_clarkpark_pipe : directed + randomised bench for clarkpark_pipe          |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_clarkpark_pipe;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    clarkpark_pipe_if #(.pw_io_width(16)) bus ();

    clarkpark_pipe #(
        .pw_io_width        (16),
        .pw_io_decimal_width(15),
        .p_2div3            (21845),
        .p_1div3            (10922),
        .p_sqrt3div3        (18918),
        .p_sqrt3div2        (28378)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit       m;
        longint   x, y, z;
        bit [2:0] f;
        int       due;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    bit     ex_valid, ex_mode, ex_sticky;
    longint ex_x, ex_y, ex_z;
    bit [2:0] ex_f;

    // Floor division by 2^15.
    function automatic longint fl(input longint v);
        if (v >= 0) return v / 32768;
        return -((-v + 32767) / 32768);
    endfunction

    function automatic longint clamp(input longint v, output bit f);
        f = 1'b1;
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        f = 1'b0;
        return v;
    endfunction

    function automatic exp_t model(input bit m, input longint a, b, c, s, co);
        exp_t   e;
        longint al, be, rx, ry, rz;
        bit     fx, fy, fz;
        if (!m) begin
            al = fl(a * 21845 - 10922 * (b + c));
            be = fl(18918 * (b - c));
            rz = fl(10922 * (a + b + c));
            rx = fl(al * co + be * s);
            ry = fl(be * co - al * s);
        end else begin
            al = fl(a * co - b * s);
            be = fl(a * s + b * co);
            rx = al;
            ry = fl(-al * 16384 + 28378 * be);
            rz = fl(-al * 16384 - 28378 * be);
        end
        e.m   = m;
        e.x   = clamp(rx, fx);
        e.y   = clamp(ry, fy);
        e.z   = clamp(rz, fz);
        e.f   = {fz, fy, fx};
        e.due = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_in(input bit v, input bit m, input int a, b, c, s, co);
        bus.i_valid    = v;
        bus.ip_mode    = m;
        bus.isp_a      = 16'(a);
        bus.isp_b      = 16'(b);
        bus.isp_c      = 16'(c);
        bus.isp_sine   = 16'(s);
        bus.isp_cosine = 16'(co);
    endtask

    // One clock edge: update the expectation model, then compare.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            q.delete();
            ex_valid = 0; ex_mode = 0; ex_x = 0; ex_y = 0; ex_z = 0; ex_f = 0; ex_sticky = 0;
        end else begin
            ex_valid = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                ex_valid = 1; ex_mode = e.m; ex_x = e.x; ex_y = e.y; ex_z = e.z; ex_f = e.f;
                if (e.f != 0) ex_sticky = 1;
                else if (bus.i_sat_clear) ex_sticky = 0;
            end else if (bus.i_sat_clear) begin
                ex_sticky = 0;
            end
            if (bus.i_valid) begin
                e = model(bus.ip_mode, bus.isp_a, bus.isp_b, bus.isp_c, bus.isp_sine, bus.isp_cosine);
                e.due = cyc + 4;
                q.push_back(e);
            end
        end
        chk("o_valid", bus.o_valid, ex_valid);
        chk("osp_x", bus.osp_x, ex_x);
        chk("osp_y", bus.osp_y, ex_y);
        chk("osp_z", bus.osp_z, ex_z);
        chk("o_sat_sticky", bus.o_sat_sticky, ex_sticky);
        if (ex_valid) begin
            chk("op_mode", bus.op_mode, ex_mode);
            chk("op_sat_flags", bus.op_sat_flags, ex_f);
        end
    endtask

    task automatic run_one(input bit m, input int a, b, c, s, co);
        set_in(1, m, a, b, c, s, co);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
    endtask

    initial begin
        int a, b, c, s, co;
        reset           = 1'b1;
        bus.i_sat_clear = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_flags", bus.op_sat_flags, 0);
        chk("rst_mode", bus.op_mode, 0);

        // Forward nominal
        run_one(0, 16384, -8192, -8192, 0, 32767);
        chk("t1_x", bus.osp_x, 16382);
        chk("t1_y", bus.osp_y, 0);
        chk("t1_z", bus.osp_z, 0);
        chk("t1_flags", bus.op_sat_flags, 0);

        // Forward saturation and sticky clear
        run_one(0, 32767, -32768, -32768, 0, 32767);
        chk("t2_x", bus.osp_x, 32767);
        chk("t2_flags", bus.op_sat_flags, 1);
        chk("t2_sticky", bus.o_sat_sticky, 1);
        bus.i_sat_clear = 1'b1;
        tick();
        bus.i_sat_clear = 1'b0;
        chk("t2_clr", bus.o_sat_sticky, 0);

        // Inverse nominal
        run_one(1, 16384, 0, 0, 0, 32767);
        chk("t3_x", bus.osp_x, 16383);
        chk("t3_y", bus.osp_y, -8192);
        chk("t3_z", bus.osp_z, -8192);
        chk("t3_mode", bus.op_mode, 1);

        // Mixed modes with a bubble
        set_in(1, 0, 16384, -8192, -8192, 0, 32767); tick();
        set_in(0, 0, 0, 0, 0, 0, 0);                 tick();
        set_in(1, 1, 16384, 0, 0, 0, 32767);         tick();
        set_in(1, 0, 16384, -8192, -8192, 0, 32767); tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick(); chk("t4_x0", bus.osp_x, 16382);
        tick(); chk("t4_hold", bus.osp_x, 16382); chk("t4_bubble", bus.o_valid, 0);
        tick(); chk("t4_x2", bus.osp_x, 16383); chk("t4_m2", bus.op_mode, 1);
        tick(); chk("t4_x3", bus.osp_x, 16382); chk("t4_m3", bus.op_mode, 0);

        // Reset with samples in flight
        run_one(0, 32767, -32768, -32768, 0, 32767);
        set_in(1, 0, 1000, 2000, -3000, 12000, 20000); tick();
        set_in(1, 1, -5000, 7000, 0, -32768, 100);     tick();
        set_in(1, 0, 30000, 30000, 30000, 500, -32768); tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t5_x", bus.osp_x, 0);
        chk("t5_flags", bus.op_sat_flags, 0);
        chk("t5_sticky", bus.o_sat_sticky, 0);
        repeat (6) tick();
        run_one(0, 16384, -8192, -8192, 0, 32767);
        chk("t5_after", bus.osp_x, 16382);

        // Randomised stream, both modes, full-range sin/cos
        for (int i = 0; i < 10000; i++) begin
            a  = int'($urandom);
            b  = int'($urandom);
            c  = int'($urandom);
            s  = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom);
            co = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom);
            set_in($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), a, b, c, s, co);
            bus.i_sat_clear = ($urandom_range(0, 19) == 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        bus.i_sat_clear = 1'b0;
        repeat (6) tick();
        chk("drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
